// File: rtl/bram_rd_stream.sv
// rtl/bram_rd_stream.sv - BRAM read sequencer emitting a valid/ready stream
// Issues reads over a programmed window, absorbs the 1-cycle BRAM latency, 2-entry output buffer.
module bram_rd_stream #(
   parameter int A_WID   = 14,
   parameter int D_WID   = 32,
   parameter bit WRAP_EN = 1'b1
) (
   input  logic             i_rdclk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [A_WID-1:0] i_base_addr,
   input  logic [A_WID:0]   i_len,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [A_WID-1:0] o_rdaddr,
   output logic             o_portb_en,
   input  logic [D_WID-1:0] i_bram_dout,
   output logic [D_WID-1:0] o_m_data,
   output logic             o_m_valid,
   output logic             o_m_last,
   input  logic             i_m_ready
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [A_WID:0] MEM_WORDS = {1'b1, {A_WID{1'b0}}};

   state_t           r_state;
   logic [A_WID-1:0] r_addr;
   logic [A_WID:0]   r_issued;
   logic [A_WID:0]   r_len;
   logic             r_inflight;
   logic             r_inflight_last;
   logic             r_done;
   logic             r_err;
   logic [D_WID-1:0] r_fifo_data [2];
   logic             r_fifo_last [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;

   logic             w_pop;
   logic             w_push;
   logic [2:0]       w_occ;
   logic             w_issue;
   logic             w_issue_last;
   logic             w_abort;
   logic [A_WID+1:0] w_sum;
   logic             w_clip;
   logic [A_WID:0]   w_room;
   logic [A_WID:0]   w_len_eff;
   logic             w_head_last;

   assign w_pop       = (r_count != 2'd0) && i_m_ready;
   assign w_push      = r_inflight;
   assign w_head_last = r_fifo_last[r_rptr];

   // Occupancy after this cycle's pop, counting the word now on bram_dout.
   assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = (r_state == S_RUN) && (r_issued != r_len) && (w_occ < 3'd2) && !i_abort;
   assign w_issue_last = (r_issued == (r_len - 1'b1));
   assign w_abort      = i_abort && (r_state != S_IDLE);

   // Without wrap, a window past the top of memory is cut short at the last address.
   assign w_sum     = {2'b00, i_base_addr} + {1'b0, i_len};
   assign w_clip    = (WRAP_EN == 1'b0) && (w_sum > {1'b0, MEM_WORDS});
   assign w_room    = MEM_WORDS - {1'b0, i_base_addr};
   assign w_len_eff = w_clip ? w_room : i_len;

   always_ff @(posedge i_rdclk or negedge i_rst) begin
      if (!i_rst) begin
         r_state         <= S_IDLE;
         r_addr          <= '0;
         r_issued        <= '0;
         r_len           <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
         r_err           <= 1'b0;
         r_wptr          <= 1'b0;
         r_rptr          <= 1'b0;
         r_count         <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_last[i] <= 1'b0;
         end
      end else begin
         r_done          <= 1'b0;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue_last;
         if (w_issue) begin
            r_addr   <= r_addr + 1'b1;
            r_issued <= r_issued + 1'b1;
         end
         if (w_push) begin
            r_fifo_data[r_wptr] <= i_bram_dout;
            r_fifo_last[r_wptr] <= r_inflight_last;
            r_wptr              <= ~r_wptr;
         end
         if (w_pop)
            r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_addr   <= i_base_addr;
                  r_issued <= '0;
                  r_len    <= w_len_eff;
                  r_err    <= w_clip;
                  if (i_len == '0)
                     r_done <= 1'b1;
                  else
                     r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_issue && ((r_issued + 1'b1) == r_len))
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_pop && w_head_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Abort discards both the buffered words and the word still coming out of the BRAM.
         if (w_abort) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_count    <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_inflight <= 1'b0;
         end
      end
   end

   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_rdaddr   = r_addr;
   assign o_portb_en = w_issue;
   assign o_m_valid  = (r_count != 2'd0);
   assign o_m_data   = r_fifo_data[r_rptr];
   assign o_m_last   = o_m_valid && w_head_last;

endmodule

// File: tb/tb_bram_rd_stream.sv
// tb/tb_bram_rd_stream.sv - directed bench for bram_rd_stream
// Two instances (wrap and clip) share stimulus; each has a behavioural BRAM with mem[i]=i+0x100.
module tb_bram_rd_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [13:0] base_addr;
   logic [14:0] len;
   logic        abort;
   logic        m_ready;

   logic        busy1, done1, err1, pe1, mv1, ml1;
   logic [13:0] ra1;
   logic [31:0] dout1, md1;
   logic        busy0, done0, err0, pe0, mv0, ml0;
   logic [13:0] ra0;
   logic [31:0] dout0, md0;

   int n_cmp  = 0;
   int n_fail = 0;
   int d1 = 0;
   int d0 = 0;
   logic [32:0] q1[$];
   logic [32:0] q0[$];
   logic [13:0] a1[$];
   logic [13:0] a0[$];

   always #5 clk = ~clk;

   bram_rd_stream #(.A_WID(14), .D_WID(32), .WRAP_EN(1'b1)) u_wrap (
      .i_rdclk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr), .i_len(len),
      .i_abort(abort), .o_busy(busy1), .o_done(done1), .o_err(err1), .o_rdaddr(ra1),
      .o_portb_en(pe1), .i_bram_dout(dout1), .o_m_data(md1), .o_m_valid(mv1),
      .o_m_last(ml1), .i_m_ready(m_ready));

   bram_rd_stream #(.A_WID(14), .D_WID(32), .WRAP_EN(1'b0)) u_clip (
      .i_rdclk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr), .i_len(len),
      .i_abort(abort), .o_busy(busy0), .o_done(done0), .o_err(err0), .o_rdaddr(ra0),
      .o_portb_en(pe0), .i_bram_dout(dout0), .o_m_data(md0), .o_m_valid(mv0),
      .o_m_last(ml0), .i_m_ready(m_ready));

   always @(posedge clk) begin
      if (pe1) dout1 <= {18'd0, ra1} + 32'h100;
      if (pe0) dout0 <= {18'd0, ra0} + 32'h100;
   end

   always @(negedge clk) begin
      if (mv1 && m_ready) q1.push_back({ml1, md1});
      if (mv0 && m_ready) q0.push_back({ml0, md0});
      if (pe1) a1.push_back(ra1);
      if (pe0) a0.push_back(ra0);
      if (done1) d1 = d1 + 1;
      if (done0) d0 = d0 + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [13:0] b, input logic [14:0] l);
      base_addr = b;
      len       = l;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((busy1 || busy0) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", 64'(n < max), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic clear_mon();
      q1.delete(); q0.delete(); a1.delete(); a0.delete();
      d1 = 0; d0 = 0;
   endtask

   initial begin
      logic [3:0] pat;
      int n_iss, n_acc, pop, saw_done;
      logic prev_stall;
      logic [31:0] prev_data;

      rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; abort = 1'b0; m_ready = 1'b1;
      dout1 = '0; dout0 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy1), 0);
      chk("rst_done", 64'(done1), 0);
      chk("rst_err", 64'(err1), 0);
      chk("rst_pe", 64'(pe1), 0);
      chk("rst_valid", 64'(mv1), 0);
      chk("rst_last", 64'(ml1), 0);
      chk("rst_data", 64'(md1), 0);
      chk("rst_addr", 64'(ra1), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic stream: base 0x10, len 4, ready held high.
      base_addr = 14'h10; len = 15'd4; start = 1'b1; #1;
      chk("basic_c0_pe", 64'(pe1), 0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("basic_pe", 64'(pe1), 64'(k <= 4));
         if (k <= 4) chk("basic_addr", 64'(ra1), 64'(14'h10 + k - 1));
         chk("basic_valid", 64'(mv1), 64'(k >= 3 && k <= 6));
         if (k >= 3 && k <= 6) begin
            chk("basic_data", 64'(md1), 64'(32'h110 + k - 3));
            chk("basic_last", 64'(ml1), 64'(k == 6));
         end
         chk("basic_done", 64'(done1), 64'(k == 7));
         chk("basic_busy", 64'(busy1), 64'(k <= 6));
         @(posedge clk); #1;
      end

      // Backpressure: len 8, ready pattern 1,0,0,1 repeating.
      pat = 4'b1001;
      n_iss = 0; n_acc = 0; saw_done = 0; prev_stall = 1'b0; prev_data = '0;
      do_start(14'h20, 15'd8);
      for (int p = 0; p < 80; p++) begin
         m_ready = pat[p % 4];
         #1;
         pop = int'(mv1 && m_ready);
         if (prev_stall) begin
            chk("bp_hold_valid", 64'(mv1), 1);
            chk("bp_hold_data", 64'(md1), 64'(prev_data));
         end
         chk("bp_credit", 64'(pe1 && ((n_iss - n_acc - pop) >= 2)), 0);
         if (pe1) chk("bp_addr", 64'(ra1), 64'(14'h20 + n_iss));
         if (pop != 0) begin
            chk("bp_data", 64'(md1), 64'(32'h120 + n_acc));
            chk("bp_last", 64'(ml1), 64'(n_acc == 7));
         end
         n_iss = n_iss + int'(pe1);
         n_acc = n_acc + pop;
         prev_stall = mv1 && !m_ready;
         prev_data = md1;
         if (done1) begin
            saw_done = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("bp_done_seen", 64'(saw_done), 1);
      chk("bp_accepted", 64'(n_acc), 8);
      chk("bp_issued", 64'(n_iss), 8);
      m_ready = 1'b1;
      @(posedge clk); #1;

      // Window crossing the top of memory: wrap instance vs clip instance.
      clear_mon();
      do_start(14'h3FFE, 15'd4);
      chk("wrap_err", 64'(err1), 0);
      chk("clip_err", 64'(err0), 1);
      wait_idle(40);
      chk("wrap_naddr", 64'(a1.size()), 4);
      chk("wrap_a0", 64'(a1[0]), 64'h3FFE);
      chk("wrap_a1", 64'(a1[1]), 64'h3FFF);
      chk("wrap_a2", 64'(a1[2]), 64'h0000);
      chk("wrap_a3", 64'(a1[3]), 64'h0001);
      chk("wrap_nbeat", 64'(q1.size()), 4);
      chk("wrap_b0", 64'(q1[0]), {31'd0, 1'b0, 32'h40FE});
      chk("wrap_b1", 64'(q1[1]), {31'd0, 1'b0, 32'h40FF});
      chk("wrap_b2", 64'(q1[2]), {31'd0, 1'b0, 32'h0100});
      chk("wrap_b3", 64'(q1[3]), {31'd0, 1'b1, 32'h0101});
      chk("clip_naddr", 64'(a0.size()), 2);
      chk("clip_nbeat", 64'(q0.size()), 2);
      chk("clip_b0", 64'(q0[0]), {31'd0, 1'b0, 32'h40FE});
      chk("clip_b1", 64'(q0[1]), {31'd0, 1'b1, 32'h40FF});
      chk("clip_done", 64'(d0), 1);
      chk("clip_err_sticky", 64'(err0), 1);

      // len 0: done the cycle after start, nothing else moves; err cleared by the start.
      clear_mon();
      base_addr = 14'h30; len = 15'd0; start = 1'b1; #1;
      chk("len0_c0_pe", 64'(pe1), 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("len0_done", 64'(done1), 1);
      chk("len0_busy", 64'(busy1), 0);
      chk("len0_valid", 64'(mv1), 0);
      chk("len0_pe", 64'(pe1), 0);
      chk("len0_err_clr", 64'(err0), 0);
      @(posedge clk); #1;
      chk("len0_done_end", 64'(done1), 0);
      chk("len0_nbeat", 64'(q1.size()), 0);

      // start while running is ignored.
      clear_mon();
      do_start(14'h40, 15'd3);
      base_addr = 14'h200; len = 15'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(40);
      chk("ign_nbeat", 64'(q1.size()), 3);
      chk("ign_b0", 64'(q1[0]), {31'd0, 1'b0, 32'h140});
      chk("ign_b1", 64'(q1[1]), {31'd0, 1'b0, 32'h141});
      chk("ign_b2", 64'(q1[2]), {31'd0, 1'b1, 32'h142});
      chk("ign_done", 64'(d1), 1);
      @(posedge clk); #1;
      chk("ign_busy_after", 64'(busy1), 0);

      // Abort with the stream stalled.
      clear_mon();
      m_ready = 1'b0;
      do_start(14'h80, 15'd16);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("abort_pre_valid", 64'(mv1), 1);
      chk("abort_pre_data", 64'(md1), 64'h180);
      abort = 1'b1; #1;
      chk("abort_pe", 64'(pe1), 0);
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_valid", 64'(mv1), 0);
      chk("abort_done", 64'(done1), 1);
      chk("abort_busy", 64'(busy1), 0);
      chk("abort_last", 64'(ml1), 0);
      @(posedge clk); #1;
      chk("abort_done_end", 64'(done1), 0);
      chk("abort_nissue", 64'(a1.size()), 2);

      // Asynchronous reset mid-transfer.
      clear_mon();
      do_start(14'h90, 15'd16);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("rstmid_pre_busy", 64'(busy1), 1);
      rst = 1'b0; #1;
      chk("rstmid_busy", 64'(busy1), 0);
      chk("rstmid_valid", 64'(mv1), 0);
      chk("rstmid_data", 64'(md1), 0);
      chk("rstmid_addr", 64'(ra1), 0);
      chk("rstmid_pe", 64'(pe1), 0);
      chk("rstmid_done", 64'(done1), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      m_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("rstmid_no_done", 64'(d1), 0);

      // Fresh start after reset.
      clear_mon();
      do_start(14'h005, 15'd2);
      wait_idle(40);
      chk("fresh_nbeat", 64'(q1.size()), 2);
      chk("fresh_b0", 64'(q1[0]), {31'd0, 1'b0, 32'h105});
      chk("fresh_b1", 64'(q1[1]), {31'd0, 1'b1, 32'h106});
      chk("fresh_done", 64'(d1), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
